// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared defaults, traceback FSM states and index helpers.
// No ports. Holds the default code/window sizes, the FSM state enum,
// the circular time-index decrement and the survivor predecessor step.
package viterbi_pkg;

    localparam int DEF_K = 7;
    localparam int DEF_D = 40;
    localparam int DEF_L = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_MERGE,
        ST_DECODE,
        ST_EMIT
    } fsm_e;

    // Step one slot back in a circular memory of the given depth.
    function automatic int ptr_dec(input int ptr, input int depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

    // Predecessor state: survivor bit enters at the MSB, state shifts right.
    function automatic int next_state(input int state, input logic b, input int m);
        return (int'(b) << (m - 1)) | (state >> 1);
    endfunction

endpackage

// File: rtl/lifo_bitstack.sv
// lifo_bitstack: single-bit stack used to reverse decoded bits into time order.
// Ports: clk, rst (async clear), push/din write a bit, pop removes the top,
// empty/count report occupancy, dout is the current top bit (0 when empty).
module lifo_bitstack #(
    parameter int DEPTH = 48,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          din,
    input  logic          pop,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          dout
);

    logic [DEPTH-1:0] stack;
    logic [CW-1:0]    top;

    assign top   = count - 1'b1;
    assign empty = (count == '0);
    assign dout  = empty ? 1'b0 : stack[top];

    always_ff @(posedge clk) begin
        if (push)
            stack[count] <= din;
    end

    // A push in the same cycle as a pop wins; the pop is not taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else
            count <= push ? count + 1'b1 : (pop && !empty) ? count - 1'b1 : count;
    end

endmodule

// File: rtl/traceback_block.sv
// traceback_block: block-mode Viterbi traceback over a circular survivor memory.
// Ports: clk, rst (async, active high); start/flush/force_state0/s_end/wr_ptr
// request and parameterise a run; busy marks a run in progress; tb_time/tb_state
// address the survivor memory and tb_surv_bit returns the addressed bit;
// dec_valid/dec_ready/dec_bit/dec_last stream the decoded bits oldest first.
module traceback_block
    import viterbi_pkg::*;
#(
    parameter int K         = DEF_K,
    parameter int D         = DEF_D,
    parameter int L         = DEF_L,
    parameter int MEM_DEPTH = D + L,
    parameter int M         = K - 1,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          flush,
    input  logic          force_state0,
    input  logic [M-1:0]  s_end,
    input  logic [AW-1:0] wr_ptr,
    output logic          busy,
    output logic [AW-1:0] tb_time,
    output logic [M-1:0]  tb_state,
    input  logic          tb_surv_bit,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic          dec_bit,
    output logic          dec_last
);

    localparam int CW = $clog2(D + L + 1);

    fsm_e          state;
    logic          flush_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_end;
    logic          step_done;
    logic [AW-1:0] next_time;
    logic [M-1:0]  next_st;
    logic          push;
    logic          pop;
    logic          empty;
    logic [CW-1:0] count;
    logic          dout;

    assign next_time = AW'(ptr_dec(int'(tb_time), MEM_DEPTH));
    assign next_st   = M'(next_state(int'(tb_state), tb_surv_bit, M));
    assign cnt_end   = (state == ST_MERGE) ? CW'(D - 1) : flush_q ? CW'(D + L - 1) : CW'(L - 1);
    assign step_done = (cnt == cnt_end);
    assign push      = (state == ST_DECODE);
    assign pop       = dec_valid && dec_ready;
    assign dec_valid = (state == ST_EMIT) && !empty;
    assign dec_bit   = dec_valid && dout;
    assign dec_last  = dec_valid && (count == CW'(1));

    lifo_bitstack #(.DEPTH(D + L), .CW(CW)) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (tb_surv_bit),
        .pop   (pop),
        .empty (empty),
        .count (count),
        .dout  (dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            flush_q  <= 1'b0;
            cnt      <= '0;
            tb_time  <= '0;
            tb_state <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    flush_q  <= flush;
                    tb_time  <= AW'(ptr_dec(int'(wr_ptr), MEM_DEPTH));
                    tb_state <= force_state0 ? '0 : s_end;
                    busy     <= 1'b1;
                    cnt      <= '0;
                    state    <= ST_PRIME;
                end
                ST_PRIME: begin
                    cnt   <= '0;
                    state <= flush_q ? ST_DECODE : ST_MERGE;
                end
                // The address advances on every step so the next survivor
                // bit is already presented when the following step needs it.
                ST_MERGE, ST_DECODE: begin
                    tb_time  <= next_time;
                    tb_state <= next_st;
                    cnt      <= step_done ? '0 : cnt + 1'b1;
                    if (step_done)
                        state <= (state == ST_MERGE) ? ST_DECODE : ST_EMIT;
                end
                ST_EMIT: if (pop && dec_last) begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
